// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter slice:
// architectural sizes, address/data types, the arbiter state encoding and
// the two-requester round-robin pick function.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // INIT: scrubbing x1..x(NUM_REGS-1); ARB: arbitration live.
    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } arb_state_t;

    // Two-way round-robin pick. A lone valid always wins; on a tie the
    // requester that did not win the last transfer gets the grant.
    // last_grant is the index (0/1) of the most recent winner.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                           input logic       last_grant);
        logic [1:0] g;
        g = 2'b00;
        if (valid == 2'b11) begin
            g = last_grant ? 2'b01 : 2'b10;
        end else begin
            g = valid;
        end
        return g;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the two request channels, the register-file write port and the
// status outputs of regfile_wr_arbiter.
//
// Handshake: each requester raises reqN_valid with stable reqN_addr and
// reqN_data and holds them until it sees reqN_ready high in the same cycle;
// that cycle is the transfer. reqN_ready is a combinational function of the
// valids only, so a requester must never make its valid depend on its ready.
//
// arb_state is a debug view of the arbiter FSM.
interface regfile_wr_arbiter_if;
    import regfile_pkg::*;

    logic       req0_valid;
    reg_addr_t  req0_addr;
    reg_data_t  req0_data;
    logic       req0_ready;

    logic       req1_valid;
    reg_addr_t  req1_addr;
    reg_data_t  req1_data;
    logic       req1_ready;

    logic       regfile_wren;
    reg_addr_t  write_addr3;
    reg_data_t  regfile_data_in3;
    logic       init_done;
    arb_state_t arb_state;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output regfile_wren, write_addr3, regfile_data_in3,
        output init_done, arb_state
    );

    // Requester / register-file side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  regfile_wren, write_addr3, regfile_data_in3,
        input  init_done, arb_state
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational on the valids;
// the last_grant pointer moves only when the caller reports a transfer
// through advance, so a stalled grant does not rotate priority.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant
);

    // Combinational one-hot grant from the current valids and pointer.
    always_comb begin
        grant = rr_pick(valid, last_grant);
    end

    // Remember who won the most recent transfer; reset favours req0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the single register-file write port between core writeback (req0)
// and an auxiliary unit (req1). All write-port outputs are registered: a
// transfer in cycle N appears on the port in cycle N+1.
//
// Build option: define REGFILE_ARB_SCRUB_EN to scrub x1..x(NUM_REGS-1) to
// INIT_VAL after reset before arbitration opens. Without it the arbiter goes
// live one cycle after reset and issues no writes on its own.
module regfile_wr_arbiter #(
    parameter int                  NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int                  ADDR_W   = regfile_pkg::ADDR_W,
    parameter int                  DATA_W   = regfile_pkg::DATA_W,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wr_arbiter_if.slave    bus
);
    import regfile_pkg::*;

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              last_grant;
    logic              transfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_ok;

    arb_state_t        state_q;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              init_done_q;

`ifdef REGFILE_ARB_SCRUB_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    logic [ADDR_W-1:0] scrub_cnt_q;
`endif

    assign valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .advance    (transfer),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Ready follows the grant once arbitration is live; a transfer is any
    // cycle with a live grant since a grant implies the matching valid.
    always_comb begin
        bus.req0_ready = init_done_q && grant[0];
        bus.req1_ready = init_done_q && grant[1];
        transfer       = init_done_q && (grant != 2'b00);
    end

    // Select the winning request's payload and decide whether it reaches
    // the register file: x0 (and anything out of range) is accepted but
    // never written.
    always_comb begin
        sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
        sel_data = grant[1] ? bus.req1_data : bus.req0_data;
        wr_ok    = (sel_addr != '0) && (32'(sel_addr) < 32'(NUM_REGS));
    end

    // Arbiter FSM with registered write-port outputs. Address and data only
    // change when a real write is issued, so they hold across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
`ifdef REGFILE_ARB_SCRUB_EN
            state_q     <= INIT;
            scrub_cnt_q <= ADDR_W'(1);
`else
            state_q     <= ARB;
`endif
        end else begin
            case (state_q)
`ifdef REGFILE_ARB_SCRUB_EN
                INIT: begin
                    wren_q      <= 1'b1;
                    addr_q      <= scrub_cnt_q;
                    data_q      <= INIT_VAL;
                    scrub_cnt_q <= scrub_cnt_q + ADDR_W'(1);
                    if (scrub_cnt_q == LAST_ADDR) begin
                        init_done_q <= 1'b1;
                        state_q     <= ARB;
                    end
                end
`endif
                default: begin
                    init_done_q <= 1'b1;
                    wren_q      <= transfer && wr_ok;
                    if (transfer && wr_ok) begin
                        addr_q <= sel_addr;
                        data_q <= sel_data;
                    end
                end
            endcase
        end
    end

    assign bus.regfile_wren     = wren_q;
    assign bus.write_addr3      = addr_q;
    assign bus.regfile_data_in3 = data_q;
    assign bus.init_done        = init_done_q;
    assign bus.arb_state        = state_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter. A behavioural model predicts
// the write port, init_done and the ready lines cycle by cycle from the
// request stream; a shadow register file captures what the DUT writes and is
// read back against directed constants and the model's memory image.
// Follows REGFILE_ARB_SCRUB_EN the same way the design does.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam reg_data_t INIT_VAL = 32'h0;
    localparam int        QDEPTH   = 512;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus();

    regfile_wr_arbiter #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;

    wr_t reqs0[QDEPTH];
    wr_t reqs1[QDEPTH];
    int  head0 = 0, tail0 = 0, head1 = 0, tail1 = 0;
    logic acc0 = 1'b0, acc1 = 1'b0;
    int  gap_pct = 0;

    // Model of the arbiter as seen from outside.
    int        c = 0;          // cycle index since reset release (C1 = first low)
    logic      m_wren = 1'b0;
    reg_addr_t m_addr = '0;
    reg_data_t m_data = '0;
    logic      m_init = 1'b0;
    int        m_last = 1;
    reg_data_t model_mem[NUM_REGS];
    reg_data_t shadow[NUM_REGS];
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int        wr_cnt = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Sample the DUT mid-cycle, compare with the model, then advance the model
    // to what the next clock edge must produce.
    task automatic monitor();
        logic v0, v1;
        int   win;
        reg_addr_t a;
        reg_data_t d;
        logic [ADDR_W+DATA_W-1:0] sb;

        c = rst ? 0 : c + 1;

        check("wren", bus.regfile_wren, m_wren);
        check("waddr", bus.write_addr3, m_addr);
        check("wdata", bus.regfile_data_in3, m_data);
        check("init_done", bus.init_done, m_init);
`ifdef REGFILE_ARB_SCRUB_EN
        check("state", bus.arb_state, m_init ? ARB : INIT);
`else
        check("state", bus.arb_state, ARB);
`endif

        if (m_wren) model_mem[m_addr] = m_data;
        if (bus.regfile_wren === 1'b1) begin
            wr_cnt++;
            if (bus.write_addr3 != '0) shadow[bus.write_addr3] = bus.regfile_data_in3;
            check("sb_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                sb = exp_q.pop_front();
                check("sb_order", {bus.write_addr3, bus.regfile_data_in3}, sb);
            end
        end

        // Expected grant from the arbitration rules.
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        win = -1;
        if (m_init) begin
            if (v0 && v1)  win = 1 - m_last;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        check("req0_ready", bus.req0_ready, 32'(win == 0));
        check("req1_ready", bus.req1_ready, 32'(win == 1));

        // Requester-side view of the handshake.
        acc0 = v0 && bus.req0_ready;
        acc1 = v1 && bus.req1_ready;
        if (acc0) head0++;
        if (acc1) head1++;

        if (rst) begin
            m_wren = 1'b0; m_addr = '0; m_data = '0; m_init = 1'b0; m_last = 1;
        end else begin
            m_wren = 1'b0;
            if (win >= 0) begin
                m_last = win;
                a = (win == 1) ? bus.req1_addr : bus.req0_addr;
                d = (win == 1) ? bus.req1_data : bus.req0_data;
                if (a != '0) begin
                    m_wren = 1'b1; m_addr = a; m_data = d;
                    exp_q.push_back({a, d});
                end
            end
`ifdef REGFILE_ARB_SCRUB_EN
            if (c + 1 >= 2 && c + 1 <= NUM_REGS) begin
                m_wren = 1'b1; m_addr = reg_addr_t'(c); m_data = INIT_VAL;
                exp_q.push_back({reg_addr_t'(c), INIT_VAL});
            end
            m_init = (c + 1 >= NUM_REGS);
`else
            m_init = (c + 1 >= 2);
`endif
        end
    endtask

    // ---------------- drivers ----------------
    // Present the head of each request list; hold a request until accepted,
    // optionally leaving random idle gaps between requests.
    task automatic drive();
        if (!bus.req0_valid || acc0) begin
            if (head0 < tail0 && $urandom_range(0, 99) >= gap_pct) begin
                bus.req0_valid = 1'b1; bus.req0_addr = reqs0[head0].addr; bus.req0_data = reqs0[head0].data;
            end else begin
                bus.req0_valid = 1'b0; bus.req0_addr = reg_addr_t'($urandom); bus.req0_data = $urandom;
            end
        end
        if (!bus.req1_valid || acc1) begin
            if (head1 < tail1 && $urandom_range(0, 99) >= gap_pct) begin
                bus.req1_valid = 1'b1; bus.req1_addr = reqs1[head1].addr; bus.req1_data = reqs1[head1].data;
            end else begin
                bus.req1_valid = 1'b0; bus.req1_addr = reg_addr_t'($urandom); bus.req1_data = $urandom;
            end
        end
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push0(input reg_addr_t a, input reg_data_t d);
        reqs0[tail0] = '{addr: a, data: d};
        tail0++;
    endtask

    task automatic push1(input reg_addr_t a, input reg_data_t d);
        reqs1[tail1] = '{addr: a, data: d};
        tail1++;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((head0 != tail0 || head1 != tail1) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(head0 == tail0 && head1 == tail1), 1);
        repeat (3) tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            model_mem[i] = '0;
            shadow[i]    = '0;
        end
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

        // Reset, with a req0 write to x31 already waiting.
        rst = 1'b1;
        push0(5'd31, 32'd131);
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
`ifdef REGFILE_ARB_SCRUB_EN
        check("boot_writes", wr_cnt, NUM_REGS);
`else
        check("boot_writes", wr_cnt, 1);
`endif
        check("x31", shadow[31], 32'd131);

        // Single requester.
        push0(5'd5, 32'hDEADBEEF);
        wait_idle(50);
        check("x5", shadow[5], 32'hDEADBEEF);

        // Contention: both requesters valid back to back.
        for (int i = 1; i <= 4; i++) begin
            push0(reg_addr_t'(i), 32'(100 + i));
            push1(reg_addr_t'(10 + i), 32'(200 + i));
        end
        wait_idle(50);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("x%0d", i), shadow[i], 32'(100 + i));
            check($sformatf("x%0d", 10 + i), shadow[10 + i], 32'(200 + i));
        end

        // Write to x0 is accepted but dropped.
        push1(5'd0, 32'h12345678);
        wait_idle(50);
        check("x0", shadow[0], 32'h0);

        // Reset in the cycle right after a req0 transfer.
        push0(5'd7, 32'hCAFE0007);
        for (int n = 0; n < 20 && head0 != tail0; n++) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
`ifdef REGFILE_ARB_SCRUB_EN
        check("x7_after_reset", shadow[7], INIT_VAL);
`else
        check("x7_after_reset", shadow[7], 32'hCAFE0007);
`endif

        // Randomized traffic with idle gaps.
        gap_pct = 30;
        for (int i = 0; i < 100; i++) begin
            push0(reg_addr_t'($urandom_range(0, NUM_REGS - 1)), $urandom);
            push1(reg_addr_t'($urandom_range(0, NUM_REGS - 1)), $urandom);
        end
        wait_idle(2000);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("rand_x%0d", i), shadow[i], model_mem[i]);
        end
        check("x0_final", shadow[0], 32'h0);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
